// File: rtl/norm_32_pkg.sv
// Shared types and constants for the norm_32 normalizer: FSM states,
// binary-search stage widths and the shift-amount width.
package norm_32_pkg;

  localparam int DATA_W   = 32;
  localparam int SA_W     = 5;
  localparam int N_STAGES = 5;

  localparam int STAGE_W0 = 16;
  localparam int STAGE_W1 = 8;
  localparam int STAGE_W2 = 4;
  localparam int STAGE_W3 = 2;
  localparam int STAGE_W4 = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [2:0] stage_t;

  localparam stage_t          LAST_STAGE = stage_t'(N_STAGES - 1);
  // Stage k decides Sa bit (SA_W-1-k), so the bit mask is this constant shifted right by k.
  localparam logic [SA_W-1:0] SA_MSB     = 5'b10000;

  function automatic int stage_width(input stage_t k);
    case (k)
      3'd0:    return STAGE_W0;
      3'd1:    return STAGE_W1;
      3'd2:    return STAGE_W2;
      3'd3:    return STAGE_W3;
      default: return STAGE_W4;
    endcase
  endfunction

endpackage

// File: rtl/norm_32_step.sv
// One binary-search stage of norm_32: decides whether the top bits of V are
// insignificant for width w and, if so, shifts them out. Signed test only when
// NORM_32_SIGNED_EN is defined.
module norm_step
  import norm_32_pkg::*;
(
  input  logic [DATA_W-1:0] v,
  input  stage_t            k,
  input  logic              mode,
  output logic [DATA_W-1:0] v_out,
  output logic              take
);

  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  int                w;
  logic [DATA_W-1:0] mask_u;
  logic              take_u;

`ifdef NORM_32_SIGNED_EN
  logic [DATA_W-1:0] mask_s;
  logic              take_s;
`else
  logic              unused_mode;
  assign unused_mode = mode;
`endif

  // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    w      = stage_width(k);
    mask_u = ~(ALL_ONES >> w);
    take_u = (v & mask_u) == '0;
`ifdef NORM_32_SIGNED_EN
    // w+1 bits must match the sign so the bit left at position 31 is still the sign.
    mask_s = ~(ALL_ONES >> (w + 1));
    take_s = ((v ^ {DATA_W{v[DATA_W-1]}}) & mask_s) == '0;
    take   = mode ? take_s : take_u;
`else
    take   = take_u;
`endif
    v_out  = take ? (v << w) : v;
  end

endmodule

// File: rtl/norm_32.sv
// norm_32: multi-cycle 32-bit normalizer (16/8/4/2/1 binary search, one stage
// per clock, start/busy/done handshake). NORM_32_SIGNED_EN enables signed mode via Arith.
module norm_32
  import norm_32_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] X,
  input  logic              Arith,
  output logic              Busy,
  output logic              Done,
  output logic [SA_W-1:0]   Sa,
  output logic [DATA_W-1:0] Norm,
  output logic              Zero
);

  state_e            state_q, state_d;
  stage_t            k_q, k_d;
  logic [DATA_W-1:0] v_q, v_d;
  logic              mode_q, mode_d;
  logic [SA_W-1:0]   sa_acc_q, sa_acc_d;
  logic [SA_W-1:0]   sa_q, sa_d;
  logic [DATA_W-1:0] norm_q, norm_d;
  logic              zero_q, zero_d;

  logic              mode_in;
  logic [DATA_W-1:0] step_v;
  logic              step_take;

`ifdef NORM_32_SIGNED_EN
  assign mode_in = Arith;
`else
  logic unused_arith;
  assign unused_arith = Arith;
  assign mode_in      = 1'b0;
`endif

  norm_step u_step (
    .v     (v_q),
    .k     (k_q),
    .mode  (mode_q),
    .v_out (step_v),
    .take  (step_take)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    v_d      = v_q;
    mode_d   = mode_q;
    sa_acc_d = sa_acc_q;
    sa_d     = sa_q;
    norm_d   = norm_q;
    zero_d   = zero_q;

    case (state_q)
      RUN: begin
        v_d = step_v;
        if (step_take) sa_acc_d = sa_acc_q | (SA_MSB >> k_q);
        if (k_q == LAST_STAGE) begin
          state_d = DONE;
          // Shifts never discard significant bits, so V ends at zero only if X was zero.
          zero_d  = (step_v == '0);
          sa_d    = zero_d ? '0 : sa_acc_d;
          norm_d  = step_v;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (Start) begin
          state_d  = RUN;
          v_d      = X;
          mode_d   = mode_in;
          sa_acc_d = '0;
          k_d      = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      v_q      <= '0;
      mode_q   <= 1'b0;
      sa_acc_q <= '0;
      sa_q     <= '0;
      norm_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      v_q      <= v_d;
      mode_q   <= mode_d;
      sa_acc_q <= sa_acc_d;
      sa_q     <= sa_d;
      norm_q   <= norm_d;
      zero_q   <= zero_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign Sa   = sa_q;
  assign Norm = norm_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_norm_32.sv
// Self-checking bench for norm_32: a reference model pushes expected results to a
// scoreboard queue at each accepted Start; a monitor pops and compares on Done.
module tb_norm_32;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] X;
  logic        Arith;
  logic        Busy;
  logic        Done;
  logic [4:0]  Sa;
  logic [31:0] Norm;
  logic        Zero;

  typedef struct {
    logic [4:0]  sa;
    logic [31:0] norm;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   cyc      = 0;

  norm_32 dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .X     (X),
    .Arith (Arith),
    .Busy  (Busy),
    .Done  (Done),
    .Sa    (Sa),
    .Norm  (Norm),
    .Zero  (Zero)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic signed_m, input int due);
    exp_t e;
    int   n;
    e.due  = due;
    e.zero = (x == 32'd0);
    n      = 0;
    if (e.zero) begin
      e.sa   = 5'd0;
      e.norm = 32'd0;
    end else begin
      if (signed_m) begin
        for (int i = 30; i >= 0; i--) begin
          if (x[i] != x[31]) break;
          n++;
        end
      end else begin
        for (int i = 31; i >= 0; i--) begin
          if (x[i]) break;
          n++;
        end
      end
      e.sa   = 5'(n);
      e.norm = x << n;
    end
    return e;
  endfunction

  // Called #1 after the accepting edge; results are due five edges later.
  task automatic push(input logic [31:0] x, input logic a);
    logic eff;
`ifdef NORM_32_SIGNED_EN
    eff = a;
`else
    eff = 1'b0;
`endif
    sb.push_back(model(x, eff, cyc + 5));
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && Done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.due));
        check("sa", 32'(Sa), 32'(e.sa));
        check("norm", Norm, e.norm);
        check("zero", 32'(Zero), 32'(e.zero));
        check("busy_at_done", 32'(Busy), 32'd0);
      end
    end
  end

  task automatic start_op(input logic [31:0] x, input logic a);
    @(negedge Clk);
    X     = x;
    Arith = a;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    push(x, a);
    Start = 1'b0;
    X     = $urandom;
    Arith = ~a;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (sb.size() == 0) break;
    end
    if (i == 40) begin
      check("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic a);
    start_op(x, a);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    Rst   = 1'b1;
    Start = 1'b0;
    X     = '0;
    Arith = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_sa", 32'(Sa), 32'd0);
    check("rst_norm", Norm, 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);
    Rst = 1'b0;

    run_op(32'h0000_0001, 1'b0);
    run_op(32'h00F0_0000, 1'b0);
    run_op(32'h0000_0000, 1'b0);
    run_op(32'hFFFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 1'b0);
    run_op(32'h0000_0001, 1'b1);
    run_op(32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_8000, 1'b1);
    run_op(32'h0000_0000, 1'b1);
    run_op(32'h4000_0000, 1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] r;
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = ~r;
      run_op(r, 1'(($urandom_range(0, 1))));
    end

    // Start during RUN is dropped: exactly one Done for the first operand.
    d0 = n_done;
    start_op(32'h0001_0000, 1'b0);
    repeat (2) @(negedge Clk);
    X     = 32'h0000_00FF;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle();
    repeat (8) @(negedge Clk);
    check("ignored_start_dones", 32'(n_done - d0), 32'd1);

    // Start held through DONE re-arms on the edge that leaves DONE.
    d0 = n_done;
    @(negedge Clk);
    X     = 32'h0000_0300;
    Arith = 1'b0;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    push(32'h0000_0300, 1'b0);
    @(negedge Clk);
    X     = 32'hFFFE_0000;
    Arith = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    push(32'hFFFE_0000, 1'b1);
    check("b2b_busy", 32'(Busy), 32'd1);
    Start = 1'b0;
    wait_idle();
    check("b2b_dones", 32'(n_done - d0), 32'd2);

    // Reset three cycles into RUN clears outputs at once and suppresses Done.
    d0 = n_done;
    start_op(32'h0000_0010, 1'b0);
    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_sa", 32'(Sa), 32'd0);
    check("abort_norm", Norm, 32'd0);
    check("abort_zero", 32'(Zero), 32'd0);
    sb.delete();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (8) @(negedge Clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    run_op(32'h0000_0100, 1'b0);
    check("after_abort_dones", 32'(n_done - d0), 32'd1);

    repeat (4) @(negedge Clk);
    check("final_pending", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
